// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Holds the FSM state encoding, the minimum frame length and frame-length arithmetic.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int MIN_DATA_LEN = 5;

  // Requested data length forced into the legal window [MIN_DATA_LEN, max_len]
  function automatic int clamp_len(input int len, input int max_len);
    if (len < MIN_DATA_LEN) return MIN_DATA_LEN;
    if (len > max_len)      return max_len;
    return len;
  endfunction

  function automatic int frame_cycles(input int len, input logic pe, input logic two,
                                      input int period);
    int p;
    p = (period < 1) ? 1 : period;
    return (2 + len + int'(pe) + int'(two)) * p;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Word/config handshake and serial-side signals of the parametrised UART transmitter.
// The master drives words and per-frame configuration; the slave is the transmitter.
interface uart_tx_param_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int LEN_WIDTH      = 5
);

  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      ready;
  logic [LEN_WIDTH-1:0]      data_len;
  logic                      parity_enable;
  logic                      parity_type;
  logic                      two_stop;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, data_len, parity_enable, parity_type, two_stop, prescale,
    input  ready, TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, data_len, parity_enable, parity_type, two_stop, prescale,
    output ready, TX_OUT, busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: tick is high in the last cycle of every bit while enabled.
// Held at zero while disabled, so each frame started from idle begins a fresh bit.
module uart_baud_tick #(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] period,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt_q;
  logic [PRESCALE_WIDTH-1:0] last_cnt;

  // A period of zero behaves exactly like a period of one
  assign last_cnt = (period == '0) ? '0 : period - 1'b1;
  assign tick     = enable && (cnt_q == last_cnt);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (!enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per handshake, framed as start/data/parity/stop.
// Length, parity, stop bits and prescale are captured per frame at accept time.
module uart_tx_param
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 16,
  parameter int LEN_WIDTH      = 5
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_param_if.slave bus
);

  tx_state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic [LEN_WIDTH-1:0]      bit_idx_q, bit_idx_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      pe_q, pe_d;
  logic                      par_q, par_d;
  logic                      two_q, two_d;
  logic                      stop_idx_q, stop_idx_d;
  logic                      tx_q, tx_d;
  logic                      busy_q;

  logic                      tick;
  logic                      accept;
  logic                      last_stop;
  logic [LEN_WIDTH-1:0]      len_in;
  logic                      par_in;

  uart_baud_tick #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud_tick (
    .CLK   (CLK),
    .RST   (RST),
    .enable(state_q != IDLE),
    .period(presc_q),
    .tick  (tick)
  );

  assign last_stop  = (state_q == STOP) && tick && (stop_idx_q == two_q);
  assign bus.ready  = (state_q == IDLE) || last_stop;
  assign accept     = bus.Data_Valid && bus.ready;
  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

  // Parity is resolved at accept time over only the bits the frame will actually send
  always_comb begin
    len_in = LEN_WIDTH'(clamp_len(int'(bus.data_len), DATA_WIDTH));
    par_in = bus.parity_type;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(len_in)) par_in ^= bus.P_DATA[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    len_d      = len_q;
    bit_idx_d  = bit_idx_q;
    presc_d    = presc_q;
    pe_d       = pe_q;
    par_d      = par_q;
    two_d      = two_q;
    stop_idx_d = stop_idx_q;
    tx_d       = 1'b1;

    if (accept) begin
      state_d    = START;
      shift_d    = bus.P_DATA;
      len_d      = len_in;
      bit_idx_d  = '0;
      presc_d    = bus.prescale;
      pe_d       = bus.parity_enable;
      par_d      = par_in;
      two_d      = bus.two_stop;
      stop_idx_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        START: begin
          if (tick) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == len_q - 1'b1) begin
              state_d    = pe_q ? PARITY : STOP;
              stop_idx_d = 1'b0;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
              shift_d   = shift_q >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_d    = STOP;
            stop_idx_d = 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_idx_q == two_q) state_d = IDLE;
            else                     stop_idx_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The line level is decided from the upcoming state so TX_OUT can be a plain flop
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      len_q      <= '0;
      bit_idx_q  <= '0;
      presc_q    <= '0;
      pe_q       <= 1'b0;
      par_q      <= 1'b0;
      two_q      <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      len_q      <= len_d;
      bit_idx_q  <= bit_idx_d;
      presc_q    <= presc_d;
      pe_q       <= pe_d;
      par_q      <= par_d;
      two_q      <= two_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE);
    end
  end

endmodule
